// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the pipelined ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand and result channels of the pipelined ALU, plus its busy indication.
interface alu_pipe_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_carry;
   logic             out_ovf;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   // The ALU side of the channels.
   modport slave (
      input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_y, out_carry, out_ovf, out_zero, out_tag, busy
   );

   // The producer/consumer side of the channels.
   modport master (
      output in_valid, in_a, in_b, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_y, out_carry, out_ovf, out_zero, out_tag, busy
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// WIDTH steps per multiply. done_o is combinational on the final step so the
// caller can capture product_o on the same edge that retires the last step.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   product_o
);

   localparam int CW = $clog2(WIDTH);

   logic               active_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;

   // Accumulate the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   assign done_o    = active_q && (cnt_q == '0);
   assign product_o = acc_d;

   // Load operands on start, then step once per clock until the counter runs out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start_i) begin
         active_q <= 1'b1;
         cnt_q    <= CW'(WIDTH - 1);
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
      end else if (active_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (cnt_q == '0) begin
            active_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready operand and result channels.
// Single-cycle ops land in the output register one edge after acceptance;
// MUL runs on the sequential multiplier and lands WIDTH edges later.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int TAG_W  = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_pipe_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic               inReady;
   logic               accept;
   logic               isMul;
   logic               mulDone;
   logic [2*WIDTH-1:0] mulProduct;
   logic [TAG_W-1:0]   mulTag_q;

   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   diff;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   resY;
   logic               resCarry;
   logic               resOvf;

   logic               outValid_q, outValid_d;
   logic [WIDTH-1:0]   outY_q, outY_d;
   logic               outCarry_q, outCarry_d;
   logic               outOvf_q, outOvf_d;
   logic [TAG_W-1:0]   outTag_q, outTag_d;

   assign inReady = (state_q == IDLE) && (!outValid_q || bus.out_ready);
   assign isMul   = MUL_EN && (bus.in_op == OP_MUL);
   assign accept  = bus.in_valid && inReady;

   assign sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
   assign diff  = bus.in_a - bus.in_b;
   assign shamt = SHW'(32'(bus.in_b[SHW-1:0]) % WIDTH);

   // Single-cycle result and flags for the op currently on the input channel.
   always_comb begin
      resY     = '0;
      resCarry = 1'b0;
      resOvf   = 1'b0;
      case (bus.in_op)
         OP_ADD: begin
            resY     = sum[WIDTH-1:0];
            resCarry = sum[WIDTH];
            resOvf   = ~(bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]) & (sum[WIDTH-1] ^ bus.in_a[WIDTH-1]);
         end
         OP_SUB: begin
            resY     = diff;
            resCarry = (bus.in_a >= bus.in_b);
            resOvf   = (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]) & (diff[WIDTH-1] ^ bus.in_a[WIDTH-1]);
         end
         OP_AND:  resY = bus.in_a & bus.in_b;
         OP_OR:   resY = bus.in_a | bus.in_b;
         OP_XOR:  resY = bus.in_a ^ bus.in_b;
         OP_SLT:  resY = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
         OP_SLTU: resY = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
         OP_SLL:  resY = bus.in_a << shamt;
         OP_SRL:  resY = bus.in_a >> shamt;
         OP_SRA:  resY = $unsigned($signed(bus.in_a) >>> shamt);
         default: resY = '0;
      endcase
   end

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (accept && isMul),
      .a_i       (bus.in_a),
      .b_i       (bus.in_b),
      .done_o    (mulDone),
      .product_o (mulProduct)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Enter MUL when a multiply is accepted, leave on the multiplier's last step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && isMul) state_d = MUL;
         MUL:     if (mulDone) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Hold the multiply's tag until its product is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mulTag_q <= '0;
      end else if (accept && isMul) begin
         mulTag_q <= bus.in_tag;
      end
   end

   // Output register: a new load takes priority over a drain in the same cycle.
   always_comb begin
      outValid_d = outValid_q;
      outY_d     = outY_q;
      outCarry_d = outCarry_q;
      outOvf_d   = outOvf_q;
      outTag_d   = outTag_q;
      if (accept && !isMul) begin
         outValid_d = 1'b1;
         outY_d     = resY;
         outCarry_d = resCarry;
         outOvf_d   = resOvf;
         outTag_d   = bus.in_tag;
      end else if (mulDone) begin
         outValid_d = 1'b1;
         outY_d     = mulProduct[WIDTH-1:0];
         outCarry_d = |mulProduct[2*WIDTH-1:WIDTH];
         outOvf_d   = 1'b0;
         outTag_d   = mulTag_q;
      end else if (outValid_q && bus.out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // Output register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         outY_q     <= '0;
         outCarry_q <= 1'b0;
         outOvf_q   <= 1'b0;
         outTag_q   <= '0;
      end else begin
         outValid_q <= outValid_d;
         outY_q     <= outY_d;
         outCarry_q <= outCarry_d;
         outOvf_q   <= outOvf_d;
         outTag_q   <= outTag_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.out_y     = outY_q;
   assign bus.out_carry = outCarry_q;
   assign bus.out_ovf   = outOvf_q;
   assign bus.out_zero  = (outY_q == '0);
   assign bus.out_tag   = outTag_q;
   assign bus.busy      = (state_q == MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: the driver pushes expected results
// from an arithmetic reference model, a monitor pops and compares on every
// result transfer.
module tb_alu_pipe;

   localparam int W  = 8;
   localparam int TW = 4;

   typedef struct {
      logic [W-1:0]  y;
      logic          c;
      logic          v;
      logic [TW-1:0] tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;
   bit   randPhase;
   exp_t expQ[$];
   int   popCycles[$];

   alu_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   alu_pipe #(
      .WIDTH  (W),
      .TAG_W  (TW),
      .MUL_EN (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference model: plain integer arithmetic on the op definitions.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [TW-1:0] tag);
      exp_t   e;
      longint ua, ub, sa, sb, r, lo, hi;
      int     sh;
      ua = longint'(a);
      ub = longint'(b);
      sa = (ua >= (64'sd1 << (W-1))) ? ua - (64'sd1 << W) : ua;
      sb = (ub >= (64'sd1 << (W-1))) ? ub - (64'sd1 << W) : ub;
      lo = -(64'sd1 << (W-1));
      hi = (64'sd1 << (W-1)) - 1;
      sh = int'(ub % W);
      r  = 0;
      e.c = 1'b0;
      e.v = 1'b0;
      e.tag = tag;
      case (op)
         4'd0: begin r = ua + ub; e.c = (r >= (64'sd1 << W)); e.v = ((sa + sb) > hi) || ((sa + sb) < lo); end
         4'd1: begin r = ua - ub; e.c = (ua >= ub); e.v = ((sa - sb) > hi) || ((sa - sb) < lo); end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: r = (sa < sb) ? 1 : 0;
         4'd6: r = (ua < ub) ? 1 : 0;
         4'd7: r = ua << sh;
         4'd8: r = ua >> sh;
         4'd9: r = sa >>> sh;
         4'd10: begin r = ua * ub; e.c = (r >= (64'sd1 << W)); end
         default: r = 0;
      endcase
      e.y = r[W-1:0];
      return e;
   endfunction

   // Drive one beat, hold it until accepted, and record the expected result.
   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [TW-1:0] tag);
      int waitCnt;
      bit done;
      waitCnt = 0;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_tag   = tag;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            expQ.push_back(model(op, a, b, tag));
            done = 1'b1;
         end else if (++waitCnt > 200) begin
            checkOutput("accept_timeout", 0, 1);
            done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Monitor: compare every result transfer against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_result", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("y", bus.out_y, e.y);
               checkOutput("carry", bus.out_carry, e.c);
               checkOutput("ovf", bus.out_ovf, e.v);
               checkOutput("zero", bus.out_zero, (e.y == '0));
               checkOutput("tag", bus.out_tag, e.tag);
               popCycles.push_back(cyc);
            end
         end
      end
   end

   initial begin
      int busyCnt;
      int highCnt;
      int w;
      total = 0;
      bad = 0;
      cyc = 0;
      randPhase = 1'b0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_op = '0;
      bus.in_tag = '0;
      bus.out_ready = 1'b1;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_out_y", bus.out_y, 0);
      checkOutput("rst_out_zero", bus.out_zero, 1);
      checkOutput("rst_in_ready", bus.in_ready, 1);
      checkOutput("rst_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Directed single-cycle ops.
      applyStimulus(4'd0, 8'h7F, 8'h01, 4'd1);
      applyStimulus(4'd1, 8'h00, 8'h01, 4'd2);
      applyStimulus(4'd5, 8'h80, 8'h01, 4'd3);
      applyStimulus(4'd6, 8'h80, 8'h01, 4'd4);
      applyStimulus(4'd9, 8'h80, 8'h0B, 4'd5);
      applyStimulus(4'd7, 8'h01, 8'h07, 4'd6);
      applyStimulus(4'd8, 8'hA5, 8'h00, 4'd7);
      applyStimulus(4'd15, 8'h12, 8'h34, 4'd8);
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back ADDs: one result per cycle, tags in order.
      popCycles.delete();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'd0, 8'(8'h10 * i), 8'h03, 4'(i));
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("b2b_count", popCycles.size(), 4);
      if (popCycles.size() == 4) begin
         for (int i = 1; i < 4; i++) begin
            checkOutput("b2b_gap", popCycles[i] - popCycles[i-1], 1);
         end
      end

      // Stall with a held result, then drain and accept in the same cycle.
      bus.out_ready = 1'b0;
      applyStimulus(4'd0, 8'h22, 8'h11, 4'd5);
      fork
         applyStimulus(4'd4, 8'hF0, 8'h0F, 4'd6);
      join_none
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_in_ready", bus.in_ready, 0);
         checkOutput("stall_out_valid", bus.out_valid, 1);
         checkOutput("stall_out_y", bus.out_y, 8'h33);
         checkOutput("stall_out_tag", bus.out_tag, 4'd5);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checkOutput("drain_accept_in_ready", bus.in_ready, 1);
      wait fork;
      repeat (2) @(posedge clk);
      #1;

      // Multiplies: busy for WIDTH cycles, result right after.
      applyStimulus(4'd10, 8'h10, 8'h10, 4'd9);
      busyCnt = 0;
      w = 0;
      @(negedge clk);
      while (bus.busy && w < 40) begin
         busyCnt++;
         w++;
         @(negedge clk);
      end
      checkOutput("mul_busy_cycles", busyCnt, W);
      checkOutput("mul_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      applyStimulus(4'd10, 8'h0F, 8'h0B, 4'd10);
      repeat (12) @(posedge clk);
      #1;

      // Reset in the middle of a multiply aborts it.
      applyStimulus(4'd10, 8'h33, 8'h44, 4'd11);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      expQ.delete();
      #1;
      checkOutput("abort_busy", bus.busy, 0);
      checkOutput("abort_out_valid", bus.out_valid, 0);
      checkOutput("abort_out_zero", bus.out_zero, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      highCnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.out_valid) highCnt++;
      end
      checkOutput("abort_no_result", highCnt, 0);
      checkOutput("abort_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Random ops with a randomly stalling consumer.
      randPhase = 1'b1;
      fork
         begin
            while (randPhase) begin
               @(posedge clk);
               #1;
               if (randPhase) bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int i = 0; i < 150; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 4'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      randPhase = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      w = 0;
      while (expQ.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      checkOutput("drain_empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
